// File: rtl/bus_rr_arbiter_if.sv
// Requester and bus-side signal bundle for bus_rr_arbiter.
// master: arbiter view (drives the bus); slave: requesters plus bus responder.
interface bus_rr_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32
);
  logic [N_PORTS-1:0]      i_req;
  logic [N_PORTS-1:0]      i_wen;
  logic [N_PORTS*XLEN-1:0] i_addr;
  logic [N_PORTS*XLEN-1:0] i_wdata;
  logic [N_PORTS*3-1:0]    i_f3;
  logic [N_PORTS-1:0]      o_ready;
  logic                    o_err;
  logic [XLEN-1:0]         o_rdata;
  logic                    o_bus_en;
  logic                    o_wr_en;
  logic [XLEN-1:0]         o_addr;
  logic [XLEN-1:0]         o_wr_data;
  logic [XLEN/8-1:0]       o_byte_en;
  logic                    i_ack;
  logic [XLEN-1:0]         i_rd_data;

  modport master (
    input  i_req, i_wen, i_addr, i_wdata, i_f3,
    input  i_ack, i_rd_data,
    output o_ready, o_err, o_rdata,
    output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
  );

  modport slave (
    output i_req, i_wen, i_addr, i_wdata, i_f3,
    output i_ack, i_rd_data,
    input  o_ready, o_err, o_rdata,
    input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin N-port arbiter onto one RISC-V style load/store bus.
// Optional ack watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input logic              i_clk,
  input logic              i_rst,
  bus_rr_arbiter_if.master bus
);
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gnt;
  logic [1:0]      r_off;
  logic [2:0]      r_f3;
  logic            r_wen;
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   r_cnt;
`endif

  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [2:0]      w_f3;
  logic            w_wen;
  logic            w_mis;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wd;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_fmt;

  // Cyclic search: first requester after the last grant wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      w_idx = IW'((int'(r_last) + i) % N_PORTS);
      if (bus.i_req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // Select the winning port's request fields.
  always_comb begin
    w_addr  = bus.i_addr[int'(w_pick)*XLEN +: XLEN];
    w_wdata = bus.i_wdata[int'(w_pick)*XLEN +: XLEN];
    w_f3    = bus.i_f3[int'(w_pick)*3 +: 3];
    w_wen   = bus.i_wen[w_pick];
  end

  // Alignment check, byte lanes and lane-shifted write data.
  always_comb begin
    w_wd = w_wdata << {w_addr[1:0], 3'b000};
    case (w_f3[1:0])
      2'b00: begin
        w_mis = 1'b0;
        w_be  = NB'(1) << w_addr[1:0];
      end
      2'b01: begin
        w_mis = w_addr[0];
        w_be  = NB'(3) << {w_addr[1], 1'b0};
      end
      default: begin
        w_mis = |w_addr[1:0];
        w_be  = NB'(15);
      end
    endcase
  end

  // Read data: shift down to bit 0, then sign/zero extend.
  always_comb begin
    w_sh = bus.i_rd_data >> {r_off, 3'b000};
    case (r_f3[1:0])
      2'b00: w_fmt = r_f3[2] ? XLEN'(w_sh[7:0])
                             : {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      2'b01: w_fmt = r_f3[2] ? XLEN'(w_sh[15:0])
                             : {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      default: w_fmt = w_sh;
    endcase
  end

  // Arbitration FSM with registered bus and response outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_last        <= IW'(N_PORTS - 1);
      r_gnt         <= '0;
      r_off         <= '0;
      r_f3          <= '0;
      r_wen         <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_cnt         <= '0;
`endif
      bus.o_ready   <= '0;
      bus.o_err     <= 1'b0;
      bus.o_rdata   <= '0;
      bus.o_bus_en  <= 1'b0;
      bus.o_wr_en   <= 1'b0;
      bus.o_addr    <= '0;
      bus.o_wr_data <= '0;
      bus.o_byte_en <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.o_ready <= '0;
          bus.o_err   <= 1'b0;
          bus.o_rdata <= '0;
          if (w_any) begin
            r_gnt  <= w_pick;
            r_last <= w_pick;
            r_off  <= w_addr[1:0];
            r_f3   <= w_f3;
            r_wen  <= w_wen;
            if (w_mis) begin
              r_state     <= S_RESP;
              bus.o_ready <= N_PORTS'(1) << w_pick;
              bus.o_err   <= 1'b1;
            end else begin
              r_state       <= S_BUSY;
              bus.o_bus_en  <= 1'b1;
              bus.o_wr_en   <= w_wen;
              bus.o_addr    <= {w_addr[XLEN-1:2], 2'b00};
              bus.o_wr_data <= w_wd;
              bus.o_byte_en <= w_be;
`ifdef BUS_TIMEOUT_EN
              r_cnt         <= '0;
`endif
            end
          end
        end
        S_BUSY: begin
          if (bus.i_ack) begin
            r_state      <= S_RESP;
            bus.o_bus_en <= 1'b0;
            bus.o_wr_en  <= 1'b0;
            bus.o_ready  <= N_PORTS'(1) << r_gnt;
            bus.o_err    <= 1'b0;
            bus.o_rdata  <= r_wen ? '0 : w_fmt;
          end
`ifdef BUS_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state      <= S_RESP;
            bus.o_bus_en <= 1'b0;
            bus.o_wr_en  <= 1'b0;
            bus.o_ready  <= N_PORTS'(1) << r_gnt;
            bus.o_err    <= 1'b1;
            bus.o_rdata  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state     <= S_IDLE;
          bus.o_ready <= '0;
          bus.o_err   <= 1'b0;
          bus.o_rdata <= '0;
        end
      endcase
    end
  end
endmodule
